prog_clk_divider: RTL
=====================

Name: prog_clk_divider

Overview:
- Multi-channel, runtime-programmable clock/tick generator. Successor to the fixed single-output divider.
- NUM_CH independent channels, each dividing i_clk by a software-written divisor.
- Each channel has a per-channel enable, a near-50% duty o_clk and a one-cycle o_tick at each period start.
- Feeds timers, UART/SPI bit clocks and slow peripheral strobes from the core clock domain.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 32, counter and divisor width in bits.
- DEFAULT_DIV, 781250, divisor loaded into every channel at reset (50 MHz / 64 Hz).

Ports:
- i_clk  input  1  core clock.
- i_reset  input  1  synchronous, active-high reset.
- i_en  input  NUM_CH  per-channel run enable.
- i_wr_en  input  1  divisor write strobe, one cycle.
- i_wr_ch  input  $clog2(NUM_CH) (min 1)  target channel of the write.
- i_wr_div  input  CNT_W  new divisor (period in i_clk cycles).
- o_clk  output  NUM_CH  divided clock per channel, registered.
- o_tick  output  NUM_CH  one-cycle pulse at each period start, registered.
- o_pending  output  NUM_CH  high while a written divisor waits to be applied.

Behaviour:
- One clock. Reset is synchronous and active-high. All state is updated only on posedge i_clk.
- Reset:
  - all counters = 0, run flags = 0;
  - active divisor = DEFAULT_DIV; pending divisor cleared;
  - o_clk = 0, o_tick = 0, o_pending = 0.
  - Reset asserted mid-period aborts the period immediately. o_clk is 0 the cycle after reset is sampled.
- Per channel state: run (registered i_en), cnt (0..D-1), active divisor D, pending divisor P, pending flag.
- Divisor clamp: any written value below 2 is stored as 2. D is never 0 or 1.
- Disabled channel (run = 0):
  - cnt held at 0; o_clk = 0; o_tick = 0.
  - A write is applied to D directly in the next cycle; o_pending stays 0.
- Enable:
  - i_en rising, sampled at edge N → at edge N+1, run = 1, cnt = 0.
  - Registered outputs then show o_clk = 1 and o_tick = 1 for that first cycle.
- Running:
  - cnt increments each cycle; cnt == D-1 wraps to 0.
  - o_clk = 1 while cnt < (D+1)/2 (integer division), else 0. Odd D gives the high phase one extra cycle.
  - o_tick = 1 exactly when cnt == 0.
- Disable while running: the cycle after i_en is sampled low, o_clk = 0 and cnt = 0. There is no partial-period completion.
- Write to a running channel:
  - P is latched and pending = 1.
  - At the wrap (cnt == D-1 → 0), D <= P and pending = 0. The new period starts glitch-free with the new divisor.
  - A second write before the wrap overwrites P; only the last value is applied.
- Write in the same cycle as the wrap:
  - The value lands in P; the wrap uses the old P or old D.
  - The new value applies at the following wrap.
- Write to a disabled channel in the same cycle as its enable rising: D takes the new value before the first period starts.
- i_wr_ch >= NUM_CH: the write is ignored and no state changes.
- Counter arithmetic is unsigned CNT_W. Overflow cannot occur because cnt <= D-1 < 2^CNT_W.

Optional Feature:
- Macro PROG_CLK_DIVIDER_SYNC_EN.
- Defined:
  - Adds input i_sync (1 bit).
  - When i_sync is sampled high, every running channel sets cnt = 0 next cycle and applies any pending P; o_tick = 1 and o_clk = 1 on all running channels.
  - Disabled channels are unaffected.
  - i_sync takes priority over a simultaneous natural wrap.
- Undefined: no i_sync port; channels are phase-independent.

Decomposition:
- Package prog_clk_divider_pkg holds:
  - MIN_DIV = 2 constant;
  - typedef div_t (logic [CNT_W-1:0] at default width);
  - function high_len(div) returning (div+1)/2.
- Sub-module prog_clk_divider_chan implements one channel: counter, run, D/P registers, output flops.
- The top level decodes writes and generates NUM_CH instances.

Test Plan:
- Reset, then i_en[0] = 1 with D = 4 → o_clk[0] pattern 1,1,0,0 repeating; o_tick[0] at cycles 1,5,9 after enable; o_pending = 0.
- Ch1, D = 5 → o_clk[1] high 3 cycles, low 2; tick period 5.
- Ch0 running at D = 4; write 6 at cnt = 1 → o_pending[0] = 1 until the wrap; next period is 6 cycles (3 high / 3 low); o_pending clears on the wrap cycle.
- Write 0 and then 1 to disabled ch2, then enable → period 2, pattern 1,0; two back-to-back writes of 8 then 10 before a wrap → only 10 applied.
- Reset pulsed mid-period on a running channel → all o_clk and o_tick go 0 the next cycle; D returns to DEFAULT_DIV; i_wr_ch = NUM_CH write → no change.
- With PROG_CLK_DIVIDER_SYNC_EN: ch0 D = 4, ch1 D = 6 at arbitrary phases; pulse i_sync → both show o_tick = 1 in the same cycle; the next coincident tick follows 12 cycles later.

Source files
------------

// File: rtl/prog_clk_divider_pkg.sv
// prog_clk_divider_pkg: shared constants, divisor type and duty-cycle helper
package prog_clk_divider_pkg;
    localparam int DIV_W   = 32;
    localparam int MIN_DIV = 2;
    typedef logic [DIV_W-1:0] div_t;
    // High-phase length (d+1)/2 computed without overflowing at the type's maximum.
    function automatic div_t high_len(input div_t d);
        return (d >> 1) + div_t'(d[0]);
    endfunction
endpackage

// File: rtl/prog_clk_divider_chan.sv
// prog_clk_divider_chan: one divider channel (run flag, counter, active/pending divisor, output flops)
// Ports: i_clk, i_reset (sync, active-high), i_en run enable, i_sync phase restart,
//        i_wr_en/i_wr_div divisor write for this channel, o_clk divided clock,
//        o_tick period-start pulse, o_pending divisor awaiting the next wrap.
module prog_clk_divider_chan
    import prog_clk_divider_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 781250
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pending
);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] RST_V = CNT_W'(DEFAULT_DIV);
    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] wr_val, hl;
    logic             running, wrap, apply;
    always_comb begin
        wr_val  = (i_wr_div < MIN_V) ? MIN_V : i_wr_div;
        running = run_q && i_en;
        // A sync pulse restarts the period exactly like a natural wrap.
        wrap    = running && (i_sync || cnt_q == div_q - ONE);
        // Pending divisors take effect at a period boundary or when the channel stops.
        apply   = wrap || !running;
        run_d   = i_en;
        cnt_d   = (running && !wrap) ? cnt_q + ONE : '0;
        // Idle (or stopping) channels take writes immediately; running ones queue them.
        div_d   = (i_wr_en && !running) ? wr_val : (apply && pend_q) ? pdiv_q : div_q;
        pdiv_d  = (i_wr_en && running) ? wr_val : pdiv_q;
        pend_d  = (i_wr_en && running) || (pend_q && !apply);
        hl      = CNT_W'(high_len(div_t'(div_d)));
        clk_d   = run_d && (cnt_d < hl);
        tick_d  = run_d && (cnt_d == '0);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            div_q  <= RST_V;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end
    assign o_clk     = clk_q;
    assign o_tick    = tick_q;
    assign o_pending = pend_q;
endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: NUM_CH runtime-programmable clock/tick dividers with per-channel enable
// Ports: i_clk, i_reset (sync, active-high), i_en per-channel enable,
//        i_wr_en/i_wr_ch/i_wr_div divisor write, o_clk divided clocks,
//        o_tick period-start pulses, o_pending queued-divisor flags.
// Optional: define PROG_CLK_DIVIDER_SYNC_EN to add i_sync, which restarts all running channels in phase.
module prog_clk_divider
    import prog_clk_divider_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 781250,
    localparam int         WCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_wr_en,
    input  logic [WCH_W-1:0]  i_wr_ch,
    input  logic [CNT_W-1:0]  i_wr_div,
`ifdef PROG_CLK_DIVIDER_SYNC_EN
    input  logic              i_sync,
`endif
    output logic [NUM_CH-1:0] o_clk,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_pending
);
    logic sync;
`ifdef PROG_CLK_DIVIDER_SYNC_EN
    assign sync = i_sync;
`else
    assign sync = 1'b0;
`endif
    // Out-of-range channel numbers match no instance, so such writes are dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        prog_clk_divider_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_en     (i_en[c]),
            .i_sync   (sync),
            .i_wr_en  (i_wr_en && (i_wr_ch == WCH_W'(c))),
            .i_wr_div (i_wr_div),
            .o_clk    (o_clk[c]),
            .o_tick   (o_tick[c]),
            .o_pending(o_pending[c])
        );
    end
endmodule
